// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmitter and its baud generator.
// The state encoding always includes PARITY, so the encoding stays the same
// whether or not the optional parity bit (macro UART_TX_PARITY_EN) is built.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Bits on the line per frame: start + 8 data + stop, plus parity if enabled
    localparam int unsigned FRAME_BITS_8N1    = 32'd10;
    localparam int unsigned FRAME_BITS_PARITY = 32'd11;

    // Level the serial line rests at between frames
    localparam logic IDLE_LEVEL = 1'b1;

    // Even parity: the XOR of all data bits
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period divider. The counter runs 0..CLK_DIV-1 and bit_tick is high in
// the cycle where it sits at CLK_DIV-1, i.e. the last cycle of a serial bit.
// Written without transmitter knowledge so a future receiver can reuse it.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   global enable; counter freezes while low
//   clear    in   forces the counter back to 0 (while enabled)
//   bit_tick out  last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max_s;

    assign at_max_s = (cnt_q == CNT_MAX);
    assign bit_tick = ena && !clear && at_max_s;

    // Next count: hold when disabled, zero on clear or wrap, else increment
    always_comb begin
        cnt_d = cnt_q;
        if (!ena) begin
            cnt_d = cnt_q;
        end else if (clear || at_max_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Byte-to-serial UART transmitter. One byte per valid/ready handshake is sent
// as start bit, DATA_BITS data bits LSB first, optional even parity, stop bit.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ena       in   global enable; all state freezes while low
//   tx_data   in   byte to send, sampled only on the accepting edge
//   tx_valid  in   upstream has a byte
//   tx_ready  out  byte can be accepted this cycle (IDLE and enabled)
//   tx        out  registered serial line, idles high
//   busy      out  frame in progress
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 accept_s;
    logic                 bit_tick_s;
    logic                 baud_clear_s;

`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // rst_n is folded in so ready is low while reset is held
    assign tx_ready     = (state_q == IDLE) && ena && rst_n;
    assign accept_s     = tx_valid && tx_ready;
    // Holding the counter at zero in IDLE means START always gets a full bit
    assign baud_clear_s = (state_q == IDLE);
    assign tx           = tx_q;
    assign busy         = busy_q;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .clear    (baud_clear_s),
        .bit_tick (bit_tick_s)
    );

    // Next-state and next line value; tx_d is the level for the NEXT cycle,
    // so each transition also loads the first level of the state it enters
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    bit_idx_d = {IDX_W{1'b0}};
                    tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = even_parity(tx_data);
`endif
                end else begin
                    tx_d = IDLE_LEVEL;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_d   = DATA;
                    bit_idx_d = {IDX_W{1'b0}};
                    tx_d      = shift_q[0];
                end else begin
                    tx_d = 1'b0;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        tx_d      = shift_d[0];
                    end
                end else begin
                    tx_d = shift_q[0];
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (bit_tick_s) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    tx_d = parity_q;
                end
`else
                // Unreachable without parity; recover to a safe idle line
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
`endif
            end
            STOP: begin
                if (bit_tick_s) begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Transmitter registers; everything holds while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= {DATA_BITS{1'b0}};
            bit_idx_q <= {IDX_W{1'b0}};
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end else begin
            state_q   <= state_q;
            shift_q   <= shift_q;
            bit_idx_q <= bit_idx_q;
            tx_q      <= tx_q;
            busy_q    <= busy_q;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured at accept because the shift register is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (ena) begin
            parity_q <= parity_d;
        end else begin
            parity_q <= parity_q;
        end
    end
`endif

endmodule
